// File: rtl/cmd_rsp_checker.sv
// cmd_rsp_checker: replays a table of configuration commands through a config
// master, compares each masked response with its expected value and reports
// pass/fail, a saturating error count and the index of the first failure.
// Build option: define STOP_ON_ERR_EN to end a run at its first failure
// (mismatch or timeout); otherwise every entry runs regardless of errors.
module cmd_rsp_checker #(
   parameter int CMD_W  = 24,
   parameter int RSP_W  = 16,
   parameter int DEPTH  = 16,
   parameter int TO_CYC = 65535
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ld_we,
   input  logic [$clog2(DEPTH)-1:0] ld_addr,
   input  logic [CMD_W-1:0]         ld_cmd,
   input  logic [RSP_W-1:0]         ld_exp,
   input  logic [RSP_W-1:0]         ld_msk,
   input  logic                     start,
   input  logic [$clog2(DEPTH):0]   num_cmds,
   output logic                     snd_frm,
   output logic [CMD_W-1:0]         cmd_data,
   input  logic                     rsp_rdy,
   input  logic [RSP_W-1:0]         resp,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [7:0]               err_cnt,
   output logic [$clog2(DEPTH)-1:0] fail_idx
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TO_CYC);
   localparam logic [AW:0]   DEPTH_N = (AW+1)'(DEPTH);
   localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

   typedef enum logic [2:0] {IDLE, SEND, WAIT, CHECK, FIN} state_t;

   state_t state, state_d;

   logic [CMD_W-1:0] tbl_cmd [DEPTH];
   logic [RSP_W-1:0] tbl_exp [DEPTH];
   logic [RSP_W-1:0] tbl_msk [DEPTH];

   logic [AW:0]      count;
   logic [AW:0]      count_in;
   logic [AW-1:0]    idx, idx_d;
   logic [TW-1:0]    to_cnt;
   logic             rdy_q;
   logic [RSP_W-1:0] resp_q;
   logic             rdy_edge, timeout, mismatch, fail_evt, last, stop;

   assign count_in = (num_cmds > DEPTH_N) ? DEPTH_N : num_cmds;
   assign rdy_edge = rsp_rdy & ~rdy_q;
   assign timeout  = (state == WAIT) && !rdy_edge && (to_cnt == TO_LAST);
   assign mismatch = (state == CHECK) && (|((resp_q ^ tbl_exp[idx]) & tbl_msk[idx]));
   assign fail_evt = timeout | mismatch;
   assign last     = ({1'b0, idx} == count - (AW+1)'(1));

`ifdef STOP_ON_ERR_EN
   assign stop = last | fail_evt;
`else
   assign stop = last;
`endif

   // Command table: writable only while idle, deliberately not reset
   always_ff @(posedge clk) begin
      if (state == IDLE && ld_we) begin
         tbl_cmd[ld_addr] <= ld_cmd;
         tbl_exp[ld_addr] <= ld_exp;
         tbl_msk[ld_addr] <= ld_msk;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // Next-state and entry-index selection
   always_comb begin
      state_d = state;
      idx_d   = idx;
      case (state)
         IDLE: begin
            if (start) begin
               idx_d   = '0;
               state_d = (count_in == '0) ? FIN : SEND;
            end
         end
         SEND: state_d = WAIT;
         WAIT: begin
            if (rdy_edge) begin
               state_d = CHECK;
            end else if (timeout) begin
               if (stop) begin
                  state_d = FIN;
               end else begin
                  idx_d   = idx + AW'(1);
                  state_d = SEND;
               end
            end
         end
         CHECK: begin
            if (stop) begin
               state_d = FIN;
            end else begin
               idx_d   = idx + AW'(1);
               state_d = SEND;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath, status outputs and run bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         idx      <= '0;
         count    <= '0;
         to_cnt   <= '0;
         rdy_q    <= 1'b0;
         resp_q   <= '0;
         snd_frm  <= 1'b0;
         cmd_data <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_cnt  <= '0;
         fail_idx <= '0;
      end else begin
         rdy_q   <= rsp_rdy;
         idx     <= idx_d;
         // snd_frm and cmd_data are loaded on entry so both are valid in SEND
         snd_frm <= (state_d == SEND);
         done    <= (state == FIN);
         if (state_d == SEND) cmd_data <= tbl_cmd[idx_d];

         if (state == WAIT) to_cnt <= to_cnt + TW'(1);
         else               to_cnt <= '0;

         if (state == WAIT && rdy_edge) resp_q <= resp;

         if (state == IDLE && start) begin
            count    <= count_in;
            err_cnt  <= '0;
            pass     <= 1'b0;
            fail_idx <= '0;
            busy     <= 1'b1;
         end

         if (fail_evt) begin
            if (err_cnt != 8'hFF) err_cnt  <= err_cnt + 8'd1;
            if (err_cnt == 8'h00) fail_idx <= idx;
         end

         if (state == FIN) begin
            busy <= 1'b0;
            pass <= (err_cnt == 8'h00);
         end
      end
   end

endmodule

// File: tb/tb_cmd_rsp_checker.sv
// Directed bench for cmd_rsp_checker: a table of run vectors (responses,
// timeouts, expected results) plus hand-written reset/latency/stale/abort runs.
module tb_cmd_rsp_checker;

   localparam logic [23:0] CMD0 = 24'h001234;

   logic        clk = 1'b0;
   logic        rst, ld_we, start, rsp_rdy;
   logic [1:0]  ld_addr;
   logic [23:0] ld_cmd;
   logic [15:0] ld_exp, ld_msk, resp;
   logic [2:0]  num_cmds;
   logic        snd_frm, busy, done, pass;
   logic [23:0] cmd_data;
   logic [7:0]  err_cnt;
   logic [1:0]  fail_idx;

   int n_vec = 0;
   int n_bad = 0;
   int snd_cnt = 0;
   int done_cnt = 0;
   int cyc = 0;

   typedef struct {
      string       name;
      int          n;
      logic [15:0] exp_v;
      logic [15:0] msk_v;
      logic [15:0] rsp [4];
      logic [3:0]  tmo;
      int          e_snd;
      int          e_err;
      int          e_fidx;
      int          e_pass;
      int          e_lat;
   } vec_t;

   vec_t vt[$];

   cmd_rsp_checker #(
      .CMD_W (24),
      .RSP_W (16),
      .DEPTH (4),
      .TO_CYC(16)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .ld_we   (ld_we),
      .ld_addr (ld_addr),
      .ld_cmd  (ld_cmd),
      .ld_exp  (ld_exp),
      .ld_msk  (ld_msk),
      .start   (start),
      .num_cmds(num_cmds),
      .snd_frm (snd_frm),
      .cmd_data(cmd_data),
      .rsp_rdy (rsp_rdy),
      .resp    (resp),
      .busy    (busy),
      .done    (done),
      .pass    (pass),
      .err_cnt (err_cnt),
      .fail_idx(fail_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (snd_frm) snd_cnt <= snd_cnt + 1;
      if (done)    done_cnt <= done_cnt + 1;
   end

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic void add_vec(input string nm, input int n, input logic [15:0] e, input logic [15:0] m,
                                   input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2,
                                   input logic [15:0] r3, input logic [3:0] tmo, input int s, input int er,
                                   input int fi, input int ps, input int lat);
      vec_t v;
      v.name = nm; v.n = n; v.exp_v = e; v.msk_v = m;
      v.rsp[0] = r0; v.rsp[1] = r1; v.rsp[2] = r2; v.rsp[3] = r3;
      v.tmo = tmo; v.e_snd = s; v.e_err = er; v.e_fidx = fi; v.e_pass = ps; v.e_lat = lat;
      vt.push_back(v);
   endfunction

   task automatic load(input int a, input logic [23:0] c, input logic [15:0] e, input logic [15:0] m);
      @(posedge clk); #1;
      ld_we = 1'b1; ld_addr = 2'(a); ld_cmd = c; ld_exp = e; ld_msk = m;
      @(posedge clk); #1;
      ld_we = 1'b0;
   endtask

   task automatic wait_snd(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (snd_frm) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
      end
   endtask

   task automatic pulse_start(input int n);
      @(posedge clk); #1;
      start = 1'b1; num_cmds = 3'(n);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int e_snd, e_err, e_lat, s0, d0, t0;
      bit ok;
      e_snd = v.e_snd; e_err = v.e_err; e_lat = v.e_lat;
`ifdef STOP_ON_ERR_EN
      if (v.e_err > 0) begin
         e_snd = v.e_fidx + 1;
         e_err = 1;
         e_lat = 0;
      end
`endif
      for (int i = 0; i < 4; i++) load(i, CMD0 + 24'(i), v.exp_v, v.msk_v);
      s0 = snd_cnt; d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; num_cmds = 3'(v.n);
      @(negedge clk);
      t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < e_snd; k++) begin
         wait_snd(ok);
         chk({v.name, ".snd_wait"}, 32'(ok), 32'd1);
         chk({v.name, ".cmd_data"}, 32'(cmd_data), 32'(CMD0) + 32'(k));
         if (!v.tmo[k]) begin
            @(posedge clk); #1;
            resp = v.rsp[k]; rsp_rdy = 1'b1;
            @(posedge clk); #1;
            rsp_rdy = 1'b0;
         end
      end
      wait_done(ok);
      chk({v.name, ".done_wait"}, 32'(ok), 32'd1);
      if (e_lat != 0) chk({v.name, ".latency"}, 32'(cyc - t0), 32'(e_lat));
      chk({v.name, ".err_cnt"}, 32'(err_cnt), 32'(e_err));
      chk({v.name, ".fail_idx"}, 32'(fail_idx), 32'(v.e_fidx));
      chk({v.name, ".pass"}, 32'(pass), 32'(v.e_pass));
      chk({v.name, ".busy"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk({v.name, ".done_single"}, 32'(done), 32'd0);
      chk({v.name, ".snd_count"}, 32'(snd_cnt - s0), 32'(e_snd));
      chk({v.name, ".done_count"}, 32'(done_cnt - d0), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      int s0, d0;

      //       name      n  exp      msk      r0       r1       r2       r3       tmo    snd err fidx pass lat
      add_vec("echo",    1, 16'h1234, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 1, 0, 0, 1, 5);
      add_vec("invalid", 3, 16'h35A6, 16'h3FFF, 16'h35A6, 16'h0A5A, 16'h35A6, 16'h0000, 4'b0000, 3, 1, 1, 0, 11);
      add_vec("masked",  2, 16'h1234, 16'h00FF, 16'hAB34, 16'h0034, 16'h0000, 16'h0000, 4'b0000, 2, 0, 0, 1, 8);
      add_vec("timeout", 2, 16'h1234, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0011, 2, 2, 0, 0, 36);
      add_vec("mixed",   3, 16'h1234, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 4'b0010, 3, 2, 1, 0, 0);
      add_vec("full",    4, 16'h1234, 16'hFFFF, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 4'b0000, 4, 0, 0, 1, 14);
      add_vec("overrun", 5, 16'h1234, 16'hFFFF, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 4'b0000, 4, 0, 0, 1, 14);
      add_vec("zero",    0, 16'h1234, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 0, 0, 0, 1, 2);
      add_vec("lastbad", 4, 16'h1234, 16'hFFFF, 16'h1234, 16'h1234, 16'h1234, 16'h1235, 4'b0000, 4, 1, 3, 0, 14);

      rst = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_cmd = '0; ld_exp = '0; ld_msk = '0;
      start = 1'b0; num_cmds = '0; rsp_rdy = 1'b0; resp = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset.snd_frm", 32'(snd_frm), 32'd0);
      chk("reset.cmd_data", 32'(cmd_data), 32'd0);
      chk("reset.busy", 32'(busy), 32'd0);
      chk("reset.done", 32'(done), 32'd0);
      chk("reset.pass", 32'(pass), 32'd0);
      chk("reset.err_cnt", 32'(err_cnt), 32'd0);
      chk("reset.fail_idx", 32'(fail_idx), 32'd0);

      foreach (vt[i]) run_vec(vt[i]);

      // Latency: start -> snd_frm next cycle; response edge -> next snd_frm two cycles later
      load(0, CMD0, 16'h1234, 16'hFFFF);
      load(1, CMD0 + 24'd1, 16'h1234, 16'hFFFF);
      pulse_start(2);
      @(negedge clk);
      chk("lat.start_snd", 32'(snd_frm), 32'd1);
      chk("lat.busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      resp = 16'h1234; rsp_rdy = 1'b1;
      @(posedge clk); #1;
      rsp_rdy = 1'b0;
      @(negedge clk);
      chk("lat.check_cycle", 32'(snd_frm), 32'd0);
      @(negedge clk);
      chk("lat.next_snd", 32'(snd_frm), 32'd1);
      chk("lat.next_cmd", 32'(cmd_data), 32'(CMD0) + 32'd1);
      @(posedge clk); #1;
      rsp_rdy = 1'b1;
      @(posedge clk); #1;
      rsp_rdy = 1'b0;
      wait_done(ok);
      chk("lat.done_wait", 32'(ok), 32'd1);
      chk("lat.pass", 32'(pass), 32'd1);

      // Stale ready level, plus start and table writes while busy must be ignored
      load(0, CMD0, 16'h1234, 16'hFFFF);
      s0 = snd_cnt; d0 = done_cnt;
      resp = 16'h0000; rsp_rdy = 1'b1;
      pulse_start(1);
      wait_snd(ok);
      chk("stale.snd_wait", 32'(ok), 32'd1);
      @(posedge clk); #1;
      ld_we = 1'b1; ld_addr = 2'd0; ld_cmd = 24'hABCDEF; ld_exp = 16'h0000; ld_msk = 16'hFFFF;
      start = 1'b1; num_cmds = 3'd3;
      @(posedge clk); #1;
      ld_we = 1'b0; start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("stale.busy", 32'(busy), 32'd1);
      chk("stale.no_done", 32'(done_cnt - d0), 32'd0);
      @(posedge clk); #1;
      rsp_rdy = 1'b0; resp = 16'h1234;
      @(posedge clk); #1;
      rsp_rdy = 1'b1;
      @(posedge clk); #1;
      rsp_rdy = 1'b0;
      wait_done(ok);
      chk("stale.done_wait", 32'(ok), 32'd1);
      chk("stale.err_cnt", 32'(err_cnt), 32'd0);
      chk("stale.pass", 32'(pass), 32'd1);
      @(posedge clk); #1;
      chk("stale.snd_count", 32'(snd_cnt - s0), 32'd1);

      // Abort: reset in WAIT clears everything and no done pulse follows
      pulse_start(1);
      wait_snd(ok);
      chk("abort.snd_wait", 32'(ok), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      d0 = done_cnt;
      @(negedge clk);
      chk("abort.busy", 32'(busy), 32'd0);
      chk("abort.snd_frm", 32'(snd_frm), 32'd0);
      chk("abort.cmd_data", 32'(cmd_data), 32'd0);
      chk("abort.err_pass", 32'({err_cnt, pass, done, fail_idx}), 32'd0);
      repeat (40) @(posedge clk);
      #1;
      chk("abort.no_done", 32'(done_cnt - d0), 32'd0);

      run_vec(vt[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
